// File: rtl/regfile_write_arbiter.sv
// Register-file write-port owner: clears every register after reset or on request,
// then shares the single write port among NREQ writeback requesters round-robin.
module regfile_write_arbiter #(
    parameter int unsigned NREQ   = 3,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned NREGS  = 32,
    localparam int unsigned SRC_W = $clog2(NREQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*DATA_W-1:0]   req_data,
    input  logic                     init_start,
    output logic                     init_busy,
    output logic                     rf_we,
    output logic [ADDR_W-1:0]        rf_waddr,
    output logic [DATA_W-1:0]        rf_wdata,
    output logic [SRC_W-1:0]         rf_wsrc
);

    typedef enum logic [0:0] {StClear, StRun} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
    logic [SRC_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic                rf_we_q, rf_we_d;
    logic [ADDR_W-1:0]   rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0]   rf_wdata_q, rf_wdata_d;
    logic [SRC_W-1:0]    rf_wsrc_q, rf_wsrc_d;

    logic                grant_valid;
    logic [SRC_W-1:0]    grant_idx;
    logic [SRC_W-1:0]    cand;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StClear;
            clr_cnt_q  <= '0;
            rr_ptr_q   <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            rf_wsrc_q  <= '0;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            rr_ptr_q   <= rr_ptr_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            rf_wsrc_q  <= rf_wsrc_d;
        end
    end

    // Rotating priority search starting at rr_ptr; grant only in RUN.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        req_ready   = '0;
        if (state_q == StRun) begin
            for (int k = 0; k < int'(NREQ); k++) begin
                cand = SRC_W'((int'(rr_ptr_q) + k) % int'(NREQ));
                if (!grant_valid && req_valid[cand]) begin
                    grant_valid = 1'b1;
                    grant_idx   = cand;
                end
            end
            if (grant_valid) begin
                req_ready[grant_idx] = 1'b1;
            end
        end
        init_busy = (state_q == StClear);
    end

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (grant_idx == SRC_W'(i)) begin
                sel_addr = req_addr[i*ADDR_W +: ADDR_W];
                sel_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        clr_cnt_d  = clr_cnt_q;
        rr_ptr_d   = rr_ptr_q;
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        rf_wsrc_d  = rf_wsrc_q;
        unique case (state_q)
            StClear: begin
                rf_we_d    = 1'b1;
                rf_waddr_d = clr_cnt_q;
                rf_wdata_d = '0;
                if (clr_cnt_q == ADDR_W'(NREGS - 1)) begin
                    state_d   = StRun;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
            StRun: begin
                if (grant_valid) begin
                    // Writes to x0 are consumed but never reach the register file.
                    rf_we_d    = |sel_addr;
                    rf_waddr_d = sel_addr;
                    rf_wdata_d = sel_data;
                    rf_wsrc_d  = grant_idx;
                    rr_ptr_d   = (grant_idx == SRC_W'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
                end
                if (init_start) begin
                    state_d   = StClear;
                    clr_cnt_d = '0;
                end
            end
            default: state_d = StClear;
        endcase
    end

    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;
    assign rf_wsrc  = rf_wsrc_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomized bench for regfile_write_arbiter against a cycle-level behavioural model
// plus a negedge-sampled register-file image.
module tb_regfile_write_arbiter;

    localparam int NREQ = 3, DATA_W = 32, ADDR_W = 5, NREGS = 32, SRC_W = 2;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [NREQ-1:0]        req_valid, req_ready;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ*DATA_W-1:0] req_data;
    logic                   init_start, init_busy, rf_we;
    logic [ADDR_W-1:0]      rf_waddr;
    logic [DATA_W-1:0]      rf_wdata;
    logic [SRC_W-1:0]       rf_wsrc;

    int checks = 0;
    int failures = 0;

    regfile_write_arbiter #(.NREQ(NREQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREGS(NREGS)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data), .init_start(init_start),
        .init_busy(init_busy), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .rf_wsrc(rf_wsrc)
    );

    always #5 clk = ~clk;

    // Register file image, written at the negedge like the real one.
    logic [DATA_W-1:0] tb_rf [NREGS];
    always @(negedge clk) if (rf_we) tb_rf[rf_waddr] <= rf_wdata;

    // Behavioural model
    bit                m_busy;
    int                m_cnt, m_ptr, last_grant;
    logic              m_we;
    logic [ADDR_W-1:0] m_waddr;
    logic [DATA_W-1:0] m_wdata;
    logic [SRC_W-1:0]  m_wsrc;

    function automatic int model_grant();
        if (m_busy) return -1;
        for (int k = 0; k < NREQ; k++)
            if (req_valid[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] model_ready();
        logic [NREQ-1:0] r = '0;
        int g = model_grant();
        if (g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    task automatic model_reset();
        m_busy = 1; m_cnt = 0; m_ptr = 0; m_we = 0; m_waddr = 0; m_wdata = 0; m_wsrc = 0;
        last_grant = -1;
    endtask

    // Advance one clock: posedge updates the model, returns at the following negedge.
    task automatic tick();
        int g;
        bit ini;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        g = model_grant();
        ini = init_start;
        a = '0; d = '0;
        if (g >= 0) begin
            a = req_addr[g*ADDR_W +: ADDR_W];
            d = req_data[g*DATA_W +: DATA_W];
        end
        @(posedge clk);
        if (m_busy) begin
            m_we = 1; m_waddr = m_cnt[ADDR_W-1:0]; m_wdata = 0;
            if (m_cnt == NREGS - 1) begin m_busy = 0; m_cnt = 0; end
            else m_cnt++;
        end else begin
            if (g >= 0) begin
                m_we = (a != 0); m_waddr = a; m_wdata = d; m_wsrc = g[SRC_W-1:0];
                m_ptr = (g + 1) % NREQ;
            end else m_we = 0;
            if (ini) begin m_busy = 1; m_cnt = 0; end
        end
        last_grant = g;
        @(negedge clk);
    endtask

    task automatic drive_random_valid();
        req_valid = NREQ'($urandom);
        for (int i = 0; i < NREQ; i++) begin
            req_addr[i*ADDR_W +: ADDR_W] = ADDR_W'($urandom);
            req_data[i*DATA_W +: DATA_W] = $urandom;
        end
    endtask

    task automatic test_reset();
        rst_n = 1; req_valid = '0; req_addr = '0; req_data = '0; init_start = 0;
        #2 rst_n = 0;
        model_reset();
        #1;
        checks++;
        if ({rf_we, rf_waddr, rf_wdata, rf_wsrc, init_busy, req_ready} !== {1'b0, 5'd0, 32'd0, 2'd0, 1'b1, 3'b000}) begin
            failures++;
            $display("FAIL reset_values: we=%b waddr=%0d wdata=%h src=%0d busy=%b ready=%b, want 0/0/0/0/1/000",
                     rf_we, rf_waddr, rf_wdata, rf_wsrc, init_busy, req_ready);
        end
        @(negedge clk);
        rst_n = 1;
        for (int c = 0; c < NREGS; c++) begin
            drive_random_valid();
            #1;
            checks++;
            if (req_ready !== 3'b000) begin
                failures++;
                $display("FAIL clear_ready c=%0d: got %b want 000", c, req_ready);
            end
            tick();
            checks++;
            if (rf_we !== 1'b1 || rf_waddr !== c[ADDR_W-1:0] || rf_wdata !== 32'd0
                || init_busy !== (c != NREGS - 1)) begin
                failures++;
                $display("FAIL clear_seq c=%0d: we=%b waddr=%0d wdata=%h busy=%b want 1/%0d/0/%b",
                         c, rf_we, rf_waddr, rf_wdata, init_busy, c, c != NREGS - 1);
            end
        end
        req_valid = '0;
        #1;
        checks++;
        if (tb_rf[NREGS-1] !== 32'd0 || tb_rf[0] !== 32'd0) begin
            failures++;
            $display("FAIL clear_rf: r0=%h r31=%h want 0", tb_rf[0], tb_rf[NREGS-1]);
        end
    endtask

    task automatic test_round_robin();
        logic [NREQ-1:0] want;
        req_valid = '1;
        for (int c = 0; c < 6; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                req_addr[i*ADDR_W +: ADDR_W] = ADDR_W'(1 + i + 3 * c);
                req_data[i*DATA_W +: DATA_W] = $urandom;
            end
            want = 3'b001 << (c % 3);
            #1;
            checks++;
            if (req_ready !== want || req_ready !== model_ready()) begin
                failures++;
                $display("FAIL rr_grant c=%0d: got %b want %b", c, req_ready, want);
            end
            tick();
            checks++;
            if (rf_we !== 1'b1 || rf_wsrc !== SRC_W'(c % 3) || rf_waddr !== m_waddr
                || rf_wdata !== m_wdata) begin
                failures++;
                $display("FAIL rr_write c=%0d: we=%b src=%0d waddr=%0d wdata=%h want 1/%0d/%0d/%h",
                         c, rf_we, rf_wsrc, rf_waddr, rf_wdata, c % 3, m_waddr, m_wdata);
            end
        end
        req_valid = '0;
    endtask

    task automatic test_single();
        req_valid = 3'b001;
        req_addr[0 +: ADDR_W] = 5'd5;
        req_data[0 +: DATA_W] = 32'hDEADBEEF;
        #1;
        checks++;
        if (req_ready !== 3'b001) begin
            failures++;
            $display("FAIL single_ready: got %b want 001", req_ready);
        end
        tick();
        req_valid = '0;
        #1;
        checks++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'hDEADBEEF
            || tb_rf[5] !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL single_write: we=%b waddr=%0d wdata=%h r5=%h want 1/5/deadbeef/deadbeef",
                     rf_we, rf_waddr, rf_wdata, tb_rf[5]);
        end
    endtask

    task automatic test_x0();
        req_valid = 3'b010;
        req_addr[ADDR_W +: ADDR_W] = 5'd0;
        req_data[DATA_W +: DATA_W] = 32'h1234;
        #1;
        checks++;
        if (req_ready !== 3'b010) begin
            failures++;
            $display("FAIL x0_ready: got %b want 010", req_ready);
        end
        tick();
        req_valid = '0;
        #1;
        checks++;
        if (rf_we !== 1'b0 || tb_rf[0] !== 32'd0 || rf_wsrc !== 2'd1) begin
            failures++;
            $display("FAIL x0_write: we=%b r0=%h src=%0d want 0/0/1", rf_we, tb_rf[0], rf_wsrc);
        end
    endtask

    task automatic test_init_restart();
        req_valid = 3'b100;
        req_addr[2*ADDR_W +: ADDR_W] = 5'd7;
        req_data[2*DATA_W +: DATA_W] = 32'hA5A5_0007;
        init_start = 1;
        #1;
        checks++;
        if (req_ready !== 3'b100) begin
            failures++;
            $display("FAIL restart_grant: got %b want 100", req_ready);
        end
        tick();
        init_start = 0;
        req_data[2*DATA_W +: DATA_W] = 32'h0BAD_F00D;
        checks++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || init_busy !== 1'b1) begin
            failures++;
            $display("FAIL restart_complete: we=%b waddr=%0d busy=%b want 1/7/1", rf_we, rf_waddr, init_busy);
        end
        for (int c = 0; c < NREGS; c++) begin
            init_start = ($urandom_range(0, 3) == 0);
            #1;
            checks++;
            if (req_ready !== 3'b000) begin
                failures++;
                $display("FAIL restart_stall c=%0d: got %b want 000", c, req_ready);
            end
            tick();
        end
        init_start = 0;
        #1;
        for (int r = 0; r < NREGS; r++) begin
            checks++;
            if (tb_rf[r] !== 32'd0) begin
                failures++;
                $display("FAIL restart_rf r%0d: got %h want 0", r, tb_rf[r]);
            end
        end
        checks++;
        if (req_ready !== 3'b100 || init_busy !== 1'b0) begin
            failures++;
            $display("FAIL restart_resume: ready=%b busy=%b want 100/0", req_ready, init_busy);
        end
        tick();
        req_valid = '0;
    endtask

    task automatic test_reset_mid_clear();
        init_start = 1;
        tick();
        init_start = 0;
        for (int c = 0; c < 10; c++) begin
            drive_random_valid();
            tick();
        end
        #2 rst_n = 0;
        model_reset();
        #1;
        checks++;
        if ({rf_we, rf_waddr, rf_wdata, rf_wsrc, init_busy, req_ready} !== {1'b0, 5'd0, 32'd0, 2'd0, 1'b1, 3'b000}) begin
            failures++;
            $display("FAIL midclear_reset: we=%b waddr=%0d wdata=%h src=%0d busy=%b ready=%b",
                     rf_we, rf_waddr, rf_wdata, rf_wsrc, init_busy, req_ready);
        end
        @(negedge clk);
        rst_n = 1;
        for (int c = 0; c < NREGS; c++) begin
            tick();
            checks++;
            if (rf_we !== 1'b1 || rf_waddr !== c[ADDR_W-1:0] || init_busy !== m_busy) begin
                failures++;
                $display("FAIL midclear_seq c=%0d: we=%b waddr=%0d busy=%b want 1/%0d/%b",
                         c, rf_we, rf_waddr, init_busy, c, m_busy);
            end
        end
    endtask

    task automatic test_random();
        int wait_grants [NREQ];
        for (int i = 0; i < NREQ; i++) wait_grants[i] = 0;
        req_valid = '0;
        for (int c = 0; c < 400; c++) begin
            // Requesters hold addr/data while valid and not yet granted.
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] || last_grant == i) begin
                    req_valid[i] = ($urandom_range(0, 2) != 0);
                    req_addr[i*ADDR_W +: ADDR_W] = ($urandom_range(0, 5) == 0) ? '0 : ADDR_W'($urandom);
                    req_data[i*DATA_W +: DATA_W] = $urandom;
                    wait_grants[i] = 0;
                end
            end
            init_start = ($urandom_range(0, 60) == 0);
            #1;
            checks++;
            if (req_ready !== model_ready()) begin
                failures++;
                $display("FAIL rand_ready c=%0d: got %b want %b", c, req_ready, model_ready());
            end
            tick();
            for (int i = 0; i < NREQ; i++)
                if (req_valid[i] && last_grant >= 0 && last_grant != i) wait_grants[i]++;
            for (int i = 0; i < NREQ; i++) begin
                if (wait_grants[i] >= NREQ) begin
                    checks++;
                    failures++;
                    $display("FAIL starvation req%0d: waited %0d grants, want < %0d", i, wait_grants[i], NREQ);
                    wait_grants[i] = 0;
                end
            end
            checks++;
            if (rf_we !== m_we || init_busy !== m_busy
                || (m_we && (rf_waddr !== m_waddr || rf_wdata !== m_wdata))
                || (!m_busy && rf_wsrc !== m_wsrc)) begin
                failures++;
                $display("FAIL rand_out c=%0d: we=%b busy=%b waddr=%0d wdata=%h src=%0d want %b/%b/%0d/%h/%0d",
                         c, rf_we, init_busy, rf_waddr, rf_wdata, rf_wsrc, m_we, m_busy, m_waddr, m_wdata, m_wsrc);
            end
        end
        req_valid = '0;
        init_start = 0;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_x0();
        test_init_restart();
        test_reset_mid_clear();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
